// File: rtl/rans_enc_ctrl_if.sv
// Signal bundle between the rANS frame controller, its config/symbol sources and the encoder datapath.
interface rans_enc_ctrl_if #(
    parameter int SYMBOL_WIDTH = 4,
    parameter int LOG_M        = 10
) ();
    // cfg_* and sym_* beats transfer on a rising clk edge where valid and ready are both high; a
    // source holds valid/data until that edge, and valid never waits on ready. dp_step is issued
    // only while dp_ready is high, so each strobe is one accepted encode step.
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [LOG_M:0]          cfg_freq;
    logic                    sym_valid;
    logic                    sym_ready;
    logic [SYMBOL_WIDTH-1:0] sym;
    logic                    dp_wr_en;
    logic [SYMBOL_WIDTH-1:0] dp_wr_sel;
    logic [LOG_M:0]          dp_wr_freq;
    logic [LOG_M:0]          dp_wr_cumul;
    logic                    dp_step;
    logic [SYMBOL_WIDTH-1:0] dp_sym;
    logic                    dp_ready;
    logic                    dp_flush;
    logic                    dp_flush_done;

    modport slave (
        input  cfg_valid, cfg_freq, sym_valid, sym, dp_ready, dp_flush_done,
        output cfg_ready, sym_ready, dp_wr_en, dp_wr_sel, dp_wr_freq, dp_wr_cumul,
               dp_step, dp_sym, dp_flush
    );

    modport master (
        output cfg_valid, cfg_freq, sym_valid, sym, dp_ready, dp_flush_done,
        input  cfg_ready, sym_ready, dp_wr_en, dp_wr_sel, dp_wr_freq, dp_wr_cumul,
               dp_step, dp_sym, dp_flush
    );
endinterface

// File: rtl/rans_enc_ctrl.sv
// rANS encoder frame sequencer: loads freq/cumul tables, checks they sum to 2^LOG_M,
// streams one frame of symbols into the datapath and finishes with a state flush.
module rans_enc_ctrl #(
    parameter int SYMBOL_WIDTH = 4,
    parameter int NUM_SYMBOLS  = 16,
    parameter int LOG_M        = 10,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] frame_len,
    rans_enc_ctrl_if.slave       bus,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic                 sym_err,
    output logic [LEN_WIDTH-1:0] sym_count,
    output logic [2:0]           state_dbg
);
    localparam int SUM_W = LOG_M + 2;
    localparam logic [SUM_W-1:0]        M_TOTAL  = SUM_W'(1) << LOG_M;
    localparam logic [SYMBOL_WIDTH-1:0] LAST_IDX = SYMBOL_WIDTH'(NUM_SYMBOLS - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CFG        = 3'd1,
        S_RUN        = 3'd2,
        S_FLUSH      = 3'd3,
        S_WAIT_FLUSH = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t state, state_next;

    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    count_q;
    logic [SYMBOL_WIDTH-1:0] index_q;
    logic [SUM_W-1:0]        sum_q;
    logic [NUM_SYMBOLS-1:0]  zero_mask_q;
    logic                    cfg_err_q;
    logic                    sym_err_q;
    logic                    wr_en_q;
    logic [SYMBOL_WIDTH-1:0] wr_sel_q;
    logic [LOG_M:0]          wr_freq_q;
    logic [LOG_M:0]          wr_cumul_q;

    logic [SUM_W-1:0]     sum_next;
    logic [LEN_WIDTH-1:0] count_next;
    logic                 last_beat;
    logic                 cfg_ready_c;
    logic                 sym_ready_c;
    logic                 cfg_fire;
    logic                 sym_fire;
    logic                 step_c;
    logic                 flush_c;

    assign sum_next   = sum_q + SUM_W'(bus.cfg_freq);
    assign count_next = count_q + LEN_WIDTH'(1);
    assign last_beat  = (index_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        cfg_ready_c = 1'b0;
        sym_ready_c = 1'b0;
        cfg_fire    = 1'b0;
        sym_fire    = 1'b0;
        step_c      = 1'b0;
        flush_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_CFG;
            end
            S_CFG: begin
                cfg_ready_c = 1'b1;
                cfg_fire    = bus.cfg_valid;
                // The sum check uses the in-flight beat so RUN can follow the last beat directly.
                if (cfg_fire && last_beat) begin
                    if (sum_next != M_TOTAL)            state_next = S_IDLE;
                    else if (len_q == '0)               state_next = S_FLUSH;
                    else                                state_next = S_RUN;
                end
            end
            S_RUN: begin
                sym_ready_c = bus.dp_ready;
                sym_fire    = bus.sym_valid & bus.dp_ready;
                step_c      = sym_fire & ~zero_mask_q[bus.sym];
                if (sym_fire && count_next == len_q) state_next = S_FLUSH;
            end
            S_FLUSH: begin
                flush_c    = 1'b1;
                state_next = S_WAIT_FLUSH;
            end
            S_WAIT_FLUSH: begin
                if (bus.dp_flush_done) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q       <= '0;
            count_q     <= '0;
            index_q     <= '0;
            sum_q       <= '0;
            zero_mask_q <= '0;
            cfg_err_q   <= 1'b0;
            sym_err_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_sel_q    <= '0;
            wr_freq_q   <= '0;
            wr_cumul_q  <= '0;
        end else begin
            wr_en_q <= cfg_fire;
            if (state == S_IDLE && start) begin
                len_q       <= frame_len;
                count_q     <= '0;
                index_q     <= '0;
                sum_q       <= '0;
                zero_mask_q <= '0;
                cfg_err_q   <= 1'b0;
                sym_err_q   <= 1'b0;
            end
            if (cfg_fire) begin
                wr_sel_q   <= index_q;
                wr_freq_q  <= bus.cfg_freq;
                wr_cumul_q <= sum_q[LOG_M:0];
                sum_q      <= sum_next;
                index_q    <= index_q + SYMBOL_WIDTH'(1);
                if (bus.cfg_freq == '0)                 zero_mask_q[index_q] <= 1'b1;
                if (last_beat && sum_next != M_TOTAL)   cfg_err_q <= 1'b1;
            end
            if (sym_fire) begin
                count_q <= count_next;
                if (zero_mask_q[bus.sym]) sym_err_q <= 1'b1;
            end
        end
    end

    assign bus.cfg_ready   = cfg_ready_c;
    assign bus.sym_ready   = sym_ready_c;
    assign bus.dp_wr_en    = wr_en_q;
    assign bus.dp_wr_sel   = wr_sel_q;
    assign bus.dp_wr_freq  = wr_freq_q;
    assign bus.dp_wr_cumul = wr_cumul_q;
    assign bus.dp_step     = step_c;
    assign bus.dp_sym      = step_c ? bus.sym : '0;
    assign bus.dp_flush    = flush_c;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign cfg_err   = cfg_err_q;
    assign sym_err   = sym_err_q;
    assign sym_count = count_q;
    assign state_dbg = state;
endmodule

// File: tb/tb_rans_enc_ctrl.sv
// Directed plus randomized frames for rans_enc_ctrl, checked against a table/queue reference model.
module tb_rans_enc_ctrl;
    localparam int SW = 4;
    localparam int NS = 16;
    localparam int LM = 10;
    localparam int LW = 16;
    localparam int M  = 1 << LM;

    typedef struct {
        logic [SW-1:0] sel;
        logic [LM:0]   freq;
        logic [LM:0]   cumul;
        int            cyc;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic          busy, done, cfg_err, sym_err;
    logic [LW-1:0] sym_count;
    logic [2:0]    state_dbg;

    rans_enc_ctrl_if #(.SYMBOL_WIDTH(SW), .LOG_M(LM)) bus ();

    rans_enc_ctrl #(
        .SYMBOL_WIDTH(SW), .NUM_SYMBOLS(NS), .LOG_M(LM), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len), .bus(bus),
        .busy(busy), .done(done), .cfg_err(cfg_err), .sym_err(sym_err),
        .sym_count(sym_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int unsigned   freq_tab[NS];
    logic [SW-1:0] syms[$];
    wr_t           wr_q[$];
    int            acc_q[$];
    logic [SW-1:0] step_q[$];
    int            flush_n;
    int            done_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Mid-cycle sample point: record every datapath-side event for the end-of-frame compare.
    task automatic at_mid();
        wr_t w;
        @(negedge clk);
        if (bus.cfg_valid && bus.cfg_ready) acc_q.push_back(cyc);
        if (bus.dp_wr_en) begin
            w.sel = bus.dp_wr_sel; w.freq = bus.dp_wr_freq; w.cumul = bus.dp_wr_cumul; w.cyc = cyc;
            wr_q.push_back(w);
        end
        if (bus.dp_step) step_q.push_back(bus.dp_sym);
        if (bus.dp_flush) flush_n++;
        if (done) done_n++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        start = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_freq = '0;
        bus.sym_valid = 1'b0; bus.sym = '0;
        bus.dp_ready = 1'b0;  bus.dp_flush_done = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " busy"}, busy, 0);
        check({name, " done"}, done, 0);
        check({name, " cfg_err"}, cfg_err, 0);
        check({name, " sym_err"}, sym_err, 0);
        check({name, " sym_count"}, sym_count, 0);
        check({name, " cfg_ready"}, bus.cfg_ready, 0);
        check({name, " sym_ready"}, bus.sym_ready, 0);
        check({name, " dp_wr_en"}, bus.dp_wr_en, 0);
        check({name, " dp_step"}, bus.dp_step, 0);
        check({name, " dp_flush"}, bus.dp_flush, 0);
    endtask

    task automatic uniform_table();
        for (int k = 0; k < NS; k++) freq_tab[k] = M / NS;
    endtask

    task automatic random_table();
        uniform_table();
        for (int n = 0; n < 40; n++) begin
            int unsigned a, b, amt;
            a = $urandom_range(0, NS - 1);
            b = $urandom_range(0, NS - 1);
            amt = $urandom_range(0, freq_tab[a]);
            freq_tab[a] -= amt;
            freq_tab[b] += amt;
        end
    endtask

    // ready_mode: 0 = dp_ready held high, 1 = repeating 1,0,0,1, 2 = random with random sym_valid.
    task automatic do_frame(input string name, input int len, input int ready_mode, input int abort_at);
        int unsigned   sum, prefix;
        logic          exp_ok, exp_serr, exp_step;
        logic [SW-1:0] exp_q[$];
        int            k, i, budget, d, done_at;
        logic          pattern[4];
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1};

        sum = 0;
        for (int n = 0; n < NS; n++) sum += freq_tab[n];
        exp_ok   = ((sum % (4 * M)) == M);
        exp_serr = 1'b0;
        exp_q    = {};
        for (int n = 0; n < len; n++) begin
            if (freq_tab[syms[n]] == 0) exp_serr = 1'b1;
            else exp_q.push_back(syms[n]);
        end
        wr_q = {}; acc_q = {}; step_q = {}; flush_n = 0; done_n = 0;

        clear_inputs();
        start = 1'b1; frame_len = LW'(len);
        at_mid();
        check({name, " idle_before_start"}, busy, 0);
        next_cycle();
        start = 1'b0;

        k = 0; budget = 0;
        while (k < NS && budget < 200) begin
            bus.cfg_valid = ($urandom_range(0, 3) != 0);
            bus.cfg_freq  = (LM + 1)'(freq_tab[k]);
            at_mid();
            if (budget == 0) check({name, " busy_after_start"}, busy, 1);
            if (bus.cfg_valid && bus.cfg_ready) k++;
            next_cycle();
            budget++;
        end
        bus.cfg_valid = 1'b0;
        check({name, " cfg_beats"}, k, NS);

        if (!exp_ok) begin
            at_mid();
            check({name, " bad_sum_idle"}, busy, 0);
            check({name, " bad_sum_cfg_err"}, cfg_err, 1);
            next_cycle();
            for (int n = 0; n < 3; n++) begin at_mid(); next_cycle(); end
            check({name, " bad_sum_no_flush"}, flush_n, 0);
            check({name, " bad_sum_no_done"}, done_n, 0);
        end else begin
            i = 0; budget = 0;
            while (i < len && budget < 400) begin
                if (i == abort_at) begin
                    bus.sym_valid = 1'b0;
                    rst_n = 1'b0;
                    at_mid();
                    next_cycle();
                    rst_n = 1'b1;
                    bus.sym_valid = 1'b1; bus.dp_ready = 1'b1; bus.cfg_valid = 1'b1;
                    at_mid();
                    check_all_zero({name, " after_reset"});
                    next_cycle();
                    check({name, " reset_no_flush"}, flush_n, 0);
                    check({name, " reset_no_done"}, done_n, 0);
                    clear_inputs();
                    return;
                end
                case (ready_mode)
                    0:       bus.dp_ready = 1'b1;
                    1:       bus.dp_ready = pattern[budget % 4];
                    default: bus.dp_ready = ($urandom_range(0, 2) != 0);
                endcase
                bus.sym_valid = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.sym = syms[i];
                at_mid();
                exp_step = bus.sym_valid && bus.dp_ready && (freq_tab[syms[i]] != 0);
                check({name, " sym_ready"}, bus.sym_ready, bus.dp_ready);
                check({name, " dp_step"}, bus.dp_step, exp_step);
                if (exp_step) check({name, " dp_sym"}, bus.dp_sym, syms[i]);
                check({name, " run_count"}, sym_count, i);
                if (bus.sym_valid && bus.sym_ready) i++;
                next_cycle();
                budget++;
            end
            check({name, " run_symbols"}, i, len);

            d = $urandom_range(0, 3);
            bus.sym_valid = 1'b1; bus.dp_ready = 1'b1;
            bus.dp_flush_done = $urandom_range(0, 1);
            at_mid();
            check({name, " flush_now"}, bus.dp_flush, 1);
            check({name, " flush_no_accept"}, bus.sym_ready, 0);
            check({name, " flush_count"}, sym_count, len);
            next_cycle();
            done_at = -1;
            for (int j = 1; j <= d + 4; j++) begin
                bus.dp_flush_done = (j > d);
                at_mid();
                check({name, " wait_no_accept"}, bus.sym_ready, 0);
                if (done && done_at < 0) done_at = j;
                next_cycle();
            end
            clear_inputs();
            check({name, " done_latency"}, done_at, d + 2);
            check({name, " flush_pulses"}, flush_n, 1);
            check({name, " done_pulses"}, done_n, 1);
            at_mid();
            check({name, " end_idle"}, busy, 0);
            check({name, " end_cfg_err"}, cfg_err, 0);
            check({name, " end_sym_err"}, sym_err, exp_serr);
            check({name, " end_count"}, sym_count, len);
            next_cycle();
            check({name, " step_total"}, step_q.size(), exp_q.size());
            for (int n = 0; n < exp_q.size() && n < step_q.size(); n++)
                check({name, " step_sym"}, step_q[n], exp_q[n]);
        end

        check({name, " wr_total"}, wr_q.size(), NS);
        prefix = 0;
        for (int n = 0; n < NS && n < wr_q.size() && n < acc_q.size(); n++) begin
            check({name, " wr_sel"}, wr_q[n].sel, n);
            check({name, " wr_freq"}, wr_q[n].freq, freq_tab[n]);
            check({name, " wr_cumul"}, wr_q[n].cumul, prefix % (2 * M));
            check({name, " wr_lag"}, wr_q[n].cyc, acc_q[n] + 1);
            prefix += freq_tab[n];
        end
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) next_cycle();
        at_mid();
        check_all_zero("reset");
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        uniform_table();
        syms = '{4'd3, 4'd3, 4'd7, 4'd0, 4'd15};
        do_frame("uniform_len5", 5, 0, -1);

        for (int k = 0; k < NS; k++) freq_tab[k] = 63;
        syms = '{4'd1, 4'd2, 4'd3, 4'd4};
        do_frame("bad_sum", 4, 0, -1);

        uniform_table();
        freq_tab[2] = 0; freq_tab[3] = 128;
        syms = '{4'd1, 4'd2, 4'd1};
        do_frame("zero_freq", 3, 0, -1);

        uniform_table();
        syms = {};
        for (int n = 0; n < 6; n++) syms.push_back(SW'($urandom_range(0, NS - 1)));
        do_frame("ready_toggle", 6, 1, -1);

        syms = {};
        do_frame("len_zero", 0, 0, -1);

        syms = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        do_frame("reset_mid_run", 5, 0, 2);

        syms = '{4'd9, 4'd10, 4'd11};
        do_frame("after_reset", 3, 0, -1);

        for (int r = 0; r < 6; r++) begin
            int len;
            random_table();
            len = $urandom_range(1, 24);
            syms = {};
            for (int n = 0; n < len; n++) syms.push_back(SW'($urandom_range(0, NS - 1)));
            do_frame($sformatf("random%0d", r), len, 2, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
